// File: rtl/nor_b_b_b_if.sv
// Operand/result bundle for the nor_b_b_b primitive.
// The master drives the operands a and b and receives y.
// The slave (the primitive) receives a and b and drives y.
interface nor_b_b_b_if #(
   parameter int unsigned WIDTH = 1
) ();
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] y;

   modport master (output a, output b, input y);
   modport slave  (input a, input b, output y);
endinterface

// File: rtl/nor_b_b_b.sv
// Bitwise two-input NOR primitive: y = ~(a | b).
// OUT_REG=0 gives a purely combinational path that ignores clock and reset.
// OUT_REG=1 registers y; the register is cleared asynchronously by an active-low reset.
module nor_b_b_b #(
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned OUT_REG = 0
) (
   input  logic       clock,
   input  logic       reset,
   nor_b_b_b_if.slave port
);

   // Reject unsupported configurations at elaboration time.
   if (WIDTH < 1) begin : g_bad_width
      $error("nor_b_b_b: WIDTH must be at least 1");
   end
   if (OUT_REG > 1) begin : g_bad_out_reg
      $error("nor_b_b_b: OUT_REG must be 0 or 1");
   end

   logic [WIDTH-1:0] nor_d;

   // Per-bit NOR of the operands; no interaction between bits.
   always_comb begin
      nor_d = ~(port.a | port.b);
   end

   if (OUT_REG == 1) begin : g_reg
      logic [WIDTH-1:0] y_q;

      // Output register: loads the NOR every rising edge, cleared while reset is low.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            y_q <= '0;
         end else begin
            y_q <= nor_d;
         end
      end

      assign port.y = y_q;
   end else begin : g_comb
      // clock and reset exist only for a uniform port list in this mode.
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clock, reset};

      assign port.y = nor_d;
   end

endmodule

// File: tb/tb_nor_b_b_b.sv
// Self-checking bench for nor_b_b_b: combinational and registered modes at widths 1 and 8.
module tb_nor_b_b_b;

   logic clock;
   logic rst_comb;
   logic rst_reg;

   int n_checks;
   int n_fail;

   nor_b_b_b_if #(.WIDTH(1)) if_c1 ();
   nor_b_b_b_if #(.WIDTH(8)) if_c8 ();
   nor_b_b_b_if #(.WIDTH(1)) if_r1 ();
   nor_b_b_b_if #(.WIDTH(8)) if_r8 ();

   nor_b_b_b #(.WIDTH(1), .OUT_REG(0)) u_c1 (.clock(clock), .reset(rst_comb), .port(if_c1.slave));
   nor_b_b_b #(.WIDTH(8), .OUT_REG(0)) u_c8 (.clock(clock), .reset(rst_comb), .port(if_c8.slave));
   nor_b_b_b #(.WIDTH(1), .OUT_REG(1)) u_r1 (.clock(clock), .reset(rst_reg),  .port(if_r1.slave));
   nor_b_b_b #(.WIDTH(8), .OUT_REG(1)) u_r8 (.clock(clock), .reset(rst_reg),  .port(if_r8.slave));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: each result bit looked up in the NOR truth table indexed by {a,b}.
   function automatic logic [7:0] ref_nor(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic       tt [4];
      tt[0] = 1'b1;  // a=0 b=0
      tt[1] = 1'b0;  // a=0 b=1
      tt[2] = 1'b0;  // a=1 b=0
      tt[3] = 1'b0;  // a=1 b=1
      for (int i = 0; i < 8; i++) begin
         r[i] = tt[{a[i], b[i]}];
      end
      return r;
   endfunction

   task automatic drive_all(input logic [7:0] a, input logic [7:0] b);
      if_c1.a = a[0]; if_c1.b = b[0];
      if_r1.a = a[0]; if_r1.b = b[0];
      if_c8.a = a;    if_c8.b = b;
      if_r8.a = a;    if_r8.b = b;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      @(negedge clock);
      rst_comb = 1'b0;
      rst_reg  = 1'b0;
      drive_all(8'h00, 8'h00);
      #1;
      n_checks++;
      if (if_r1.y !== 1'b0) begin
         n_fail++; $display("FAIL reset_r1 got=%b exp=0", if_r1.y);
      end
      n_checks++;
      if (if_r8.y !== 8'h00) begin
         n_fail++; $display("FAIL reset_r8 got=%h exp=00", if_r8.y);
      end
      e = ref_nor(8'h00, 8'h00);
      n_checks++;
      if (if_c1.y !== e[0]) begin
         n_fail++; $display("FAIL comb_in_reset_00 got=%b exp=%b", if_c1.y, e[0]);
      end
      drive_all(8'h01, 8'h00);
      #1;
      e = ref_nor(8'h01, 8'h00);
      n_checks++;
      if (if_c1.y !== e[0]) begin
         n_fail++; $display("FAIL comb_in_reset_10 got=%b exp=%b", if_c1.y, e[0]);
      end
      // Clock edges while reset is held must not disturb the registered outputs.
      @(posedge clock); #1;
      n_checks++;
      if (if_r1.y !== 1'b0 || if_r8.y !== 8'h00) begin
         n_fail++; $display("FAIL reset_hold_edge got=%b/%h exp=0/00", if_r1.y, if_r8.y);
      end
   endtask

   task automatic test_truth_table();
      logic [1:0] pairs [4];
      logic [7:0] e;
      pairs[0] = 2'b00; pairs[1] = 2'b10; pairs[2] = 2'b01; pairs[3] = 2'b11;
      @(negedge clock);
      rst_comb = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if_c1.a = pairs[i][1];
         if_c1.b = pairs[i][0];
         @(posedge clock); #1;
         e = ref_nor({7'd0, pairs[i][1]}, {7'd0, pairs[i][0]});
         n_checks++;
         if (if_c1.y !== e[0]) begin
            n_fail++; $display("FAIL truth_ab=%b got=%b exp=%b", pairs[i], if_c1.y, e[0]);
         end
      end
   endtask

   task automatic test_wide();
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic [7:0] vy [3];
      va[0] = 8'hF0; vb[0] = 8'h0C; vy[0] = 8'h03;
      va[1] = 8'h00; vb[1] = 8'h00; vy[1] = 8'hFF;
      va[2] = 8'hFF; vb[2] = 8'h00; vy[2] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         if_c8.a = va[i];
         if_c8.b = vb[i];
         #1;
         n_checks++;
         if (if_c8.y !== vy[i]) begin
            n_fail++; $display("FAIL wide_%0d got=%h exp=%h", i, if_c8.y, vy[i]);
         end
      end
   endtask

   task automatic test_reg_release();
      @(negedge clock);
      drive_all(8'h00, 8'h00);
      rst_reg = 1'b1;
      #1;
      n_checks++;
      if (if_r1.y !== 1'b0) begin
         n_fail++; $display("FAIL release_pre_edge got=%b exp=0", if_r1.y);
      end
      @(posedge clock); #1;
      n_checks++;
      if (if_r1.y !== 1'b1 || if_r8.y !== 8'hFF) begin
         n_fail++; $display("FAIL release_first_edge got=%b/%h exp=1/ff", if_r1.y, if_r8.y);
      end
      @(negedge clock);
      drive_all(8'h01, 8'h00);
      #1;
      n_checks++;
      if (if_r1.y !== 1'b1) begin
         n_fail++; $display("FAIL reg_hold_before_edge got=%b exp=1", if_r1.y);
      end
      @(posedge clock); #1;
      n_checks++;
      if (if_r1.y !== 1'b0 || if_r8.y !== 8'hFE) begin
         n_fail++; $display("FAIL reg_after_edge got=%b/%h exp=0/fe", if_r1.y, if_r8.y);
      end
   endtask

   task automatic test_reg_async();
      @(negedge clock);
      drive_all(8'h00, 8'h00);
      @(posedge clock); #1;
      n_checks++;
      if (if_r1.y !== 1'b1) begin
         n_fail++; $display("FAIL async_setup got=%b exp=1", if_r1.y);
      end
      #2;
      rst_reg = 1'b0;
      #1;
      n_checks++;
      if (if_r1.y !== 1'b0 || if_r8.y !== 8'h00) begin
         n_fail++; $display("FAIL async_clear got=%b/%h exp=0/00", if_r1.y, if_r8.y);
      end
      @(posedge clock); #1;
      n_checks++;
      if (if_r1.y !== 1'b0 || if_r8.y !== 8'h00) begin
         n_fail++; $display("FAIL async_held got=%b/%h exp=0/00", if_r1.y, if_r8.y);
      end
      @(negedge clock);
      rst_reg = 1'b1;
      #1;
      n_checks++;
      if (if_r1.y !== 1'b0) begin
         n_fail++; $display("FAIL async_release_no_edge got=%b exp=0", if_r1.y);
      end
      @(posedge clock); #1;
      n_checks++;
      if (if_r1.y !== 1'b1 || if_r8.y !== 8'hFF) begin
         n_fail++; $display("FAIL async_release_edge got=%b/%h exp=1/ff", if_r1.y, if_r8.y);
      end
   endtask

   task automatic test_random();
      logic [7:0] ra, rb, e, prev;
      prev = 8'hFF;  // state left by test_reg_async (inputs still 0/0)
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         ra = 8'($urandom);
         rb = 8'($urandom);
         drive_all(ra, rb);
         e = ref_nor(ra, rb);
         #1;
         n_checks++;
         if (if_c8.y !== e || if_c1.y !== e[0]) begin
            n_fail++; $display("FAIL rand_comb a=%h b=%h got=%h/%b exp=%h", ra, rb, if_c8.y, if_c1.y, e);
         end
         n_checks++;
         if (if_r8.y !== prev || if_r1.y !== prev[0]) begin
            n_fail++; $display("FAIL rand_reg_hold got=%h/%b exp=%h", if_r8.y, if_r1.y, prev);
         end
         @(posedge clock); #1;
         n_checks++;
         if (if_r8.y !== e || if_r1.y !== e[0]) begin
            n_fail++; $display("FAIL rand_reg a=%h b=%h got=%h/%b exp=%h", ra, rb, if_r8.y, if_r1.y, e);
         end
         prev = e;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_comb = 1'b1;
      rst_reg  = 1'b1;
      drive_all(8'h00, 8'h00);
      test_reset();
      test_truth_table();
      test_wide();
      test_reg_release();
      test_reg_async();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nor_b_b_b.md
Name: nor_b_b_b

Overview:
- Bitwise two-input NOR primitive for boolean (b) operands producing a boolean result; naming follows the op_type_type_type convention of the primitive library.
- Used as a leaf cell by generated netlists and by the CI primitive regression.
- Default configuration is purely combinational, with zero latency.
- Clock and reset are carried for interface uniformity with the rest of the primitive library.

Parameters:
- WIDTH, 1, operand and result width in bits; the default of 1 is the boolean "b" type.
- OUT_REG, 0, output mode.
  - 0: y is combinational from a and b.
  - 1: y is registered, adding one cycle of latency.

Ports:
- clock  input  1  single clock for the block; used only when OUT_REG=1.
- reset  input  1  asynchronous reset, active-low; used only when OUT_REG=1.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- y  output  WIDTH  result, equal to ~(a | b) bitwise.

Behaviour:
- Function: y[i] = NOT (a[i] OR b[i]) for every bit i. There is no cross-bit interaction, carry or reduction.
- OUT_REG=0 (default):
  - y is a pure combinational function of the current a and b, with zero cycles of latency.
  - y settles within the same cycle in which a or b change.
  - A bench sampling y on the clock edge sees the NOR of the a and b values applied in the preceding cycle.
  - clock and reset have no effect on y.
  - Asserting reset (reset=0) does not force y; y still equals ~(a|b).
  - No internal state exists.
- OUT_REG=1:
  - y is taken from a WIDTH-bit register loaded with ~(a|b) on every rising edge of clock.
  - Latency is one cycle.
  - reset=0 asynchronously clears the register to all zeros, regardless of clock; y=0 while reset is held low.
  - On release (reset 0->1), the first rising edge loads ~(a|b).
  - A reset asserted mid-operation discards the in-flight value immediately.
- No X-propagation special-casing; standard 4-state semantics apply.
- Unknown or unused parameter values are not supported. OUT_REG is restricted to 0 or 1, and WIDTH must be at least 1. Elaboration fails on illegal values.
- Truth table per bit:
  - a=0, b=0 -> y=1
  - a=1, b=0 -> y=0
  - a=0, b=1 -> y=0
  - a=1, b=1 -> y=0

Test Plan:
- Default config, a=0, b=0 held after reset deasserts -> y=1 on the next sampled edge.
- Default config, sequence (a,b) = (1,0), (0,1), (1,1), one pair per cycle -> y=0 sampled one edge after each pair is applied. Set a fail flag on any mismatch and a finish flag after the last check.
- Default config, hold reset=0 while applying a=0, b=0 -> y=1 (reset does not gate the combinational output); then a=1 -> y=0 in the same cycle.
- WIDTH=8, a=8'hF0, b=8'h0C -> y=8'h03; a=8'h00, b=8'h00 -> y=8'hFF; a=8'hFF, b=8'h00 -> y=8'h00.
- OUT_REG=1, WIDTH=1:
  - reset=0 -> y=0 immediately, without a clock edge.
  - Release reset with a=0, b=0 -> y=1 after the first rising edge.
  - Apply a=1 -> y stays 1 until the next edge, then becomes 0.
- OUT_REG=1: assert reset=0 asynchronously between edges while y=1 -> y=0 before the next rising edge; y remains 0 until reset is released and an edge occurs.
